m_dm_banked: RTL and testbench
==============================

Name: m_dm_banked

Overview:
- Next-generation data memory for the M stage.
- Parametrised depth, base address and wait-state count.
- Valid/ready request and one-cycle response pulse, so the pipeline can stall on slow memory.
- Word/half/byte loads (sign- or zero-extended) and stores via byte lanes; misaligned and out-of-range accesses flagged as exceptions and never written.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_CYCLES, 0, extra cycles between acceptance and response (0..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready at posedge.
- req_we  in  1  1=store, 0=load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low 8/16 bits used for byte/half.
- req_width  in  2  WORD=2'b00, HALF=2'b01, BYTE=2'b10; 2'b11 is illegal.
- req_sign  in  1  1=sign-extend load, 0=zero-extend.
- req_pc  in  32  PC of the instruction, for the store trace.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and exceptions.
- resp_exc  out  2  0=none, 1=load address error, 2=store address error.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_exc=0, wait counter 0.
- Reset clears all RAM words to 0 in the same edge.
- Reset mid-operation aborts the request; no write, no response.
- State machine IDLE / WAIT / RESP:
  - req_ready = (state==IDLE || state==RESP).
  - Acceptance latches we, addr, wdata, width, sign, pc.
  - On accept: go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else go to RESP.
  - WAIT decrements the counter; at 0 go to RESP.
  - RESP: resp_valid=1 for exactly one cycle. Then a new acceptance in that cycle follows the accept rule above; otherwise go to IDLE.
  - Latency: resp_valid is high in cycle N+1 after the accept edge, N=WAIT_CYCLES.
  - With N=0, back-to-back throughput is one request per cycle.
- Access timing: load read and store commit both happen on the edge entering RESP; response outputs are registered.
- Index: (addr - BASE_ADDR) >> 2.
- Exception checks:
  - Out of range if (addr - BASE_ADDR) >= 4*DEPTH_WORDS, using unsigned 32-bit wrap, so addr<BASE is also out of range.
  - Misaligned if WORD with addr[1:0]!=0, or HALF with addr[0]!=0.
  - Width 2'b11 is always an exception.
  - On exception: no RAM change, rdata=0, exc=1 for loads and 2 for stores.
- Lane select: HALF uses addr[1] (0 = bits 15:0, 1 = bits 31:16). BYTE uses addr[1:0] (lane k = bits 8k+7:8k).
- Store: only the selected lanes are written; other bytes keep their value.
- Load extension: the selected lane fills the low bits; upper bits are the lane MSB if sign=1, else 0.
- Store trace on each committed store, simulation only: $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, merged_word). merged_word is the full word value after the write, not the old value.
- req_valid while req_ready=0 is ignored; the requester must hold it.

Decomposition:
- Shared macro file (extends the existing one):
  - WORD/HALF/BYTE width codes.
  - EXC_NONE/EXC_ADEL/EXC_ADES codes.
  - State encodings.
- One sub-module, dm_lane_unit, is combinational:
  - inputs: width, addr[1:0], sign, old word, wdata.
  - outputs: byte-enable[3:0], merged store word, extended load value, misalign flag.
- The top holds the RAM, FSM, counter, range check and trace.

Test Plan:
- Word path (N=0): store 0x12345678 at 0x10, then load word at 0x10. Required: load rdata=0x12345678; the store response occurs the cycle after accept; trace shows "*00000010 <= 12345678".
- Byte store + signed/unsigned byte loads: after the word path, store byte 0xAB at 0x11. Required: word at 0x10 = 0x1234AB78. Signed byte load at 0x11 returns 0xFFFFFFAB; unsigned returns 0x000000AB.
- Half loads: half load at 0x12, signed then unsigned, with the word at 0x10 = 0x8001_5678. Required: signed 0xFFFF8001, unsigned 0x00008001.
- Exceptions:
  - Word load at 0x02 gives exc=1, rdata=0.
  - Half store at 0x13 gives exc=2 and the RAM word is unchanged.
  - Load at 4*DEPTH_WORDS gives exc=1.
- Wait states: WAIT_CYCLES=3, load at t0. Required: req_ready=0 for 3 cycles, resp_valid exactly at t0+4. With N=0, 4 back-to-back requests all complete with one response per cycle.
- Reset mid-operation: assert reset during WAIT of a store. Required: no write committed, no resp_valid, req_ready=1 next cycle, and a load of any word returns 0.

Source files
------------

// File: rtl/m_dm_banked_pkg.sv
// Shared definitions for the banked M-stage data memory: width codes,
// exception codes, FSM state encoding and a lane extension helper.
package m_dm_banked_pkg;

   localparam logic [1:0] W_WORD = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_BYTE = 2'b10;

   localparam logic [1:0] EXC_NONE = 2'b00;
   localparam logic [1:0] EXC_ADEL = 2'b01;
   localparam logic [1:0] EXC_ADES = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } dm_state_e;

   // Extends a selected byte or halfword lane to 32 bits, signed or unsigned.
   function automatic logic [31:0] extend_lane(input logic [15:0] lane,
                                               input logic is_half,
                                               input logic sign);
      logic [31:0] result;
      if (is_half) begin
         result = {{16{sign & lane[15]}}, lane};
      end else begin
         result = {{24{sign & lane[7]}}, lane[7:0]};
      end
      return result;
   endfunction

endpackage

// File: rtl/m_dm_banked_lane_unit.sv
// Combinational lane logic: byte enables, store merge, load extraction and
// extension, and alignment check for one access.
module dm_lane_unit
   import m_dm_banked_pkg::*;
(
   input  logic [1:0]  width,
   input  logic [1:0]  addr_lo,
   input  logic        sign,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [3:0]  byte_en,
   output logic [31:0] merged_word,
   output logic [31:0] load_word,
   output logic        misalign
);

   logic [15:0] lane_s;
   logic        is_half_s;
   logic        is_word_s;
   logic [31:0] wdata_rep_s;

   // Decode width and low address bits into lane selection and alignment.
   always_comb begin
      byte_en   = 4'b0000;
      lane_s    = 16'h0000;
      is_half_s = 1'b0;
      is_word_s = 1'b0;
      misalign  = 1'b0;
      case (width)
         W_WORD: begin
            is_word_s = 1'b1;
            byte_en   = 4'b1111;
            misalign  = (addr_lo != 2'b00);
         end
         W_HALF: begin
            is_half_s = 1'b1;
            misalign  = addr_lo[0];
            if (addr_lo[1]) begin
               byte_en = 4'b1100;
               lane_s  = old_word[31:16];
            end else begin
               byte_en = 4'b0011;
               lane_s  = old_word[15:0];
            end
         end
         W_BYTE: begin
            byte_en = 4'b0001 << addr_lo;
            case (addr_lo)
               2'b00:   lane_s = {8'h00, old_word[7:0]};
               2'b01:   lane_s = {8'h00, old_word[15:8]};
               2'b10:   lane_s = {8'h00, old_word[23:16]};
               2'b11:   lane_s = {8'h00, old_word[31:24]};
               default: lane_s = 16'h0000;
            endcase
         end
         default: begin
            misalign = 1'b1;
         end
      endcase
   end

   // Replicate store data across lanes and merge only the enabled bytes.
   always_comb begin
      if (is_word_s) begin
         wdata_rep_s = wdata;
      end else if (is_half_s) begin
         wdata_rep_s = {2{wdata[15:0]}};
      end else begin
         wdata_rep_s = {4{wdata[7:0]}};
      end
      for (int k = 0; k < 4; k++) begin
         if (byte_en[k]) begin
            merged_word[8*k +: 8] = wdata_rep_s[8*k +: 8];
         end else begin
            merged_word[8*k +: 8] = old_word[8*k +: 8];
         end
      end
   end

   // Produce the extended load value for the selected lane.
   always_comb begin
      if (is_word_s) begin
         load_word = old_word;
      end else if (byte_en == 4'b0000) begin
         load_word = 32'h0000_0000;
      end else begin
         load_word = extend_lane(lane_s, is_half_s, sign);
      end
   end

endmodule

// File: rtl/m_dm_banked.sv
// Banked data memory for the M stage: valid/ready request, optional wait
// states, one-cycle registered response, range/alignment exceptions.
module m_dm_banked
   import m_dm_banked_pkg::*;
#(
   parameter int          DEPTH_WORDS = 3072,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 0
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_width,
   input  logic        req_sign,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_exc
);

   localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] RANGE_BYTES = 32'(DEPTH_WORDS) * 32'd4;
   localparam logic [3:0]  WAIT_INIT   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   dm_state_e   state_r;
   logic [3:0]  cnt_r;
   logic        ready_r;
   logic        we_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [1:0]  width_r;
   logic        sign_r;
   logic [31:0] pc_r;
   logic        resp_valid_r;
   logic [31:0] resp_rdata_r;
   logic [1:0]  resp_exc_r;
   logic [31:0] ram_r [DEPTH_WORDS];

   logic             accept_s;
   logic             going_resp_s;
   logic             acc_we_s;
   logic [31:0]      acc_addr_s;
   logic [31:0]      acc_wdata_s;
   logic [1:0]       acc_width_s;
   logic             acc_sign_s;
   logic [31:0]      acc_pc_s;
   logic [31:0]      off_s;
   logic             oor_s;
   logic [IDX_W-1:0] idx_s;
   logic [31:0]      old_word_s;
   logic             exc_s;
   logic [1:0]       exc_code_s;
   logic [3:0]       byte_en_s;
   logic [31:0]      merged_word_s;
   logic [31:0]      load_word_s;
   logic             misalign_s;

   assign req_ready  = ready_r;
   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign resp_exc   = resp_exc_r;

   // Select the access operands: a fresh request when it enters RESP
   // directly, otherwise the latched request finishing its wait.
   always_comb begin
      accept_s = req_valid & ready_r;
      if (accept_s) begin
         acc_we_s    = req_we;
         acc_addr_s  = req_addr;
         acc_wdata_s = req_wdata;
         acc_width_s = req_width;
         acc_sign_s  = req_sign;
         acc_pc_s    = req_pc;
      end else begin
         acc_we_s    = we_r;
         acc_addr_s  = addr_r;
         acc_wdata_s = wdata_r;
         acc_width_s = width_r;
         acc_sign_s  = sign_r;
         acc_pc_s    = pc_r;
      end
      if (accept_s && (WAIT_CYCLES == 0)) begin
         going_resp_s = 1'b1;
      end else if ((state_r == ST_WAIT) && (cnt_r == 4'd0)) begin
         going_resp_s = 1'b1;
      end else begin
         going_resp_s = 1'b0;
      end
   end

   // Range check with unsigned wrap, word index and old-word read.
   always_comb begin
      off_s = acc_addr_s - BASE_ADDR;
      oor_s = (off_s >= RANGE_BYTES);
      idx_s = IDX_W'(off_s >> 2);
      if (oor_s) begin
         old_word_s = 32'h0000_0000;
      end else begin
         old_word_s = ram_r[idx_s];
      end
      exc_s = oor_s | misalign_s;
      if (!exc_s) begin
         exc_code_s = EXC_NONE;
      end else if (acc_we_s) begin
         exc_code_s = EXC_ADES;
      end else begin
         exc_code_s = EXC_ADEL;
      end
   end

   dm_lane_unit u_lane (
      .width       (acc_width_s),
      .addr_lo     (acc_addr_s[1:0]),
      .sign        (acc_sign_s),
      .old_word    (old_word_s),
      .wdata       (acc_wdata_s),
      .byte_en     (byte_en_s),
      .merged_word (merged_word_s),
      .load_word   (load_word_s),
      .misalign    (misalign_s)
   );

   // Request FSM, wait counter, request latches and registered response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 4'd0;
         ready_r      <= 1'b1;
         we_r         <= 1'b0;
         addr_r       <= 32'h0000_0000;
         wdata_r      <= 32'h0000_0000;
         width_r      <= W_WORD;
         sign_r       <= 1'b0;
         pc_r         <= 32'h0000_0000;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_exc_r   <= EXC_NONE;
      end else begin
         case (state_r)
            ST_IDLE, ST_RESP: begin
               if (accept_s) begin
                  we_r    <= req_we;
                  addr_r  <= req_addr;
                  wdata_r <= req_wdata;
                  width_r <= req_width;
                  sign_r  <= req_sign;
                  pc_r    <= req_pc;
                  if (WAIT_CYCLES > 0) begin
                     state_r <= ST_WAIT;
                     cnt_r   <= WAIT_INIT;
                     ready_r <= 1'b0;
                  end else begin
                     state_r <= ST_RESP;
                     ready_r <= 1'b1;
                  end
               end else begin
                  state_r <= ST_IDLE;
                  ready_r <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (cnt_r == 4'd0) begin
                  state_r <= ST_RESP;
                  ready_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               ready_r <= 1'b1;
            end
         endcase
         resp_valid_r <= going_resp_s;
         if (going_resp_s && !exc_s && !acc_we_s) begin
            resp_rdata_r <= load_word_s;
         end else begin
            resp_rdata_r <= 32'h0000_0000;
         end
         if (going_resp_s) begin
            resp_exc_r <= exc_code_s;
         end else begin
            resp_exc_r <= EXC_NONE;
         end
      end
   end

   // RAM: cleared on reset, store commits the enabled lanes on entering RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            ram_r[i] <= 32'h0000_0000;
         end
      end else if (going_resp_s && acc_we_s && !exc_s) begin
         for (int k = 0; k < 4; k++) begin
            if (byte_en_s[k]) begin
               ram_r[idx_s][8*k +: 8] <= merged_word_s[8*k +: 8];
            end
         end
      end
   end

`ifndef SYNTHESIS
   // Store trace of every committed store, showing the merged word.
   always_ff @(posedge clk) begin
      if (!reset && going_resp_s && acc_we_s && !exc_s) begin
         $display("%d@%h: *%h <= %h", $time, acc_pc_s, {acc_addr_s[31:2], 2'b00}, merged_word_s);
      end
   end
`endif

endmodule

// File: tb/tb_m_dm_banked.sv
// Directed bench for m_dm_banked: zero-wait instance for the data paths and
// exceptions, three-wait instance for latency and mid-operation reset.
module tb_m_dm_banked;

   localparam logic [1:0] WD = 2'b00;
   localparam logic [1:0] HF = 2'b01;
   localparam logic [1:0] BT = 2'b10;
   localparam logic [1:0] BAD = 2'b11;

   logic        clk = 1'b0;
   logic        reset0 = 1'b1;
   logic        reset3 = 1'b1;
   logic        v0 = 1'b0;
   logic        v3 = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [1:0]  width = 2'b00;
   logic        sign = 1'b0;
   logic [31:0] pc = 32'h0;

   logic        ready0, rv0, ready3, rv3;
   logic [31:0] rd0, rd3;
   logic [1:0]  exc0, exc3;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   m_dm_banked u0 (
      .clk(clk), .reset(reset0), .req_valid(v0), .req_ready(ready0),
      .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_width(width),
      .req_sign(sign), .req_pc(pc), .resp_valid(rv0), .resp_rdata(rd0),
      .resp_exc(exc0)
   );

   m_dm_banked #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3)) u3 (
      .clk(clk), .reset(reset3), .req_valid(v3), .req_ready(ready3),
      .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_width(width),
      .req_sign(sign), .req_pc(pc), .resp_valid(rv3), .resp_rdata(rd3),
      .resp_exc(exc3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] wd, input logic s);
      we = w; addr = a; wdata = d; width = wd; sign = s; pc = pc + 32'd4;
   endtask

   // One zero-wait request: accepted at the next edge, response right after.
   task automatic req0(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] wd, input logic s,
                       input logic [31:0] exp_rd, input logic [1:0] exp_exc);
      drive(w, a, d, wd, s);
      v0 = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".valid"}, {31'd0, rv0}, 32'd1);
      chk({tag, ".rdata"}, rd0, exp_rd);
      chk({tag, ".exc"}, {30'd0, exc0}, {30'd0, exp_exc});
   endtask

   task automatic idle0(input string tag);
      v0 = 1'b0;
      @(posedge clk); #1;
      chk({tag, ".pulse_end"}, {31'd0, rv0}, 32'd0);
   endtask

   // One three-wait request: ready low for 3 cycles, response on the 4th.
   task automatic req3(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] wd, input logic s,
                       input logic [31:0] exp_rd, input logic [1:0] exp_exc);
      drive(w, a, d, wd, s);
      v3 = 1'b1;
      @(posedge clk); #1;
      v3 = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         chk({tag, ".wait_ready"}, {31'd0, ready3}, 32'd0);
         chk({tag, ".wait_valid"}, {31'd0, rv3}, 32'd0);
         @(posedge clk); #1;
      end
      chk({tag, ".valid"}, {31'd0, rv3}, 32'd1);
      chk({tag, ".ready"}, {31'd0, ready3}, 32'd1);
      chk({tag, ".rdata"}, rd3, exp_rd);
      chk({tag, ".exc"}, {30'd0, exc3}, {30'd0, exp_exc});
      @(posedge clk); #1;
      chk({tag, ".pulse_end"}, {31'd0, rv3}, 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst.ready", {31'd0, ready0}, 32'd1);
      chk("rst.valid", {31'd0, rv0}, 32'd0);
      chk("rst.rdata", rd0, 32'd0);
      chk("rst.exc", {30'd0, exc0}, 32'd0);
      chk("rst3.ready", {31'd0, ready3}, 32'd1);
      reset0 = 1'b0;
      reset3 = 1'b0;

      // Word path
      req0("sw10", 1'b1, 32'h10, 32'h1234_5678, WD, 1'b0, 32'h0, 2'd0);
      idle0("sw10");
      req0("lw10", 1'b0, 32'h10, 32'h0, WD, 1'b0, 32'h1234_5678, 2'd0);
      idle0("lw10");

      // Byte store and byte loads
      req0("sb11", 1'b1, 32'h11, 32'hFFFF_FFAB, BT, 1'b0, 32'h0, 2'd0);
      req0("lw10b", 1'b0, 32'h10, 32'h0, WD, 1'b0, 32'h1234_AB78, 2'd0);
      req0("lb11", 1'b0, 32'h11, 32'h0, BT, 1'b1, 32'hFFFF_FFAB, 2'd0);
      req0("lbu11", 1'b0, 32'h11, 32'h0, BT, 1'b0, 32'h0000_00AB, 2'd0);

      // Half loads
      req0("sw10h", 1'b1, 32'h10, 32'h8001_5678, WD, 1'b0, 32'h0, 2'd0);
      req0("lh12", 1'b0, 32'h12, 32'h0, HF, 1'b1, 32'hFFFF_8001, 2'd0);
      req0("lhu12", 1'b0, 32'h12, 32'h0, HF, 1'b0, 32'h0000_8001, 2'd0);
      req0("lh10", 1'b0, 32'h10, 32'h0, HF, 1'b1, 32'h0000_5678, 2'd0);
      req0("lb13", 1'b0, 32'h13, 32'h0, BT, 1'b1, 32'hFFFF_FF80, 2'd0);

      // Exceptions
      req0("lw02", 1'b0, 32'h02, 32'h0, WD, 1'b0, 32'h0, 2'd1);
      req0("sh13", 1'b1, 32'h13, 32'h0000_BEEF, HF, 1'b0, 32'h0, 2'd2);
      req0("lw10x", 1'b0, 32'h10, 32'h0, WD, 1'b0, 32'h8001_5678, 2'd0);
      req0("lw_oor", 1'b0, 32'h3000, 32'h0, WD, 1'b0, 32'h0, 2'd1);
      req0("sw_last", 1'b1, 32'h2FFC, 32'hCAFE_F00D, WD, 1'b0, 32'h0, 2'd0);
      req0("lw_last", 1'b0, 32'h2FFC, 32'h0, WD, 1'b0, 32'hCAFE_F00D, 2'd0);
      req0("sb_wrap", 1'b1, 32'hFFFF_FFFC, 32'h11, BT, 1'b0, 32'h0, 2'd2);
      req0("lbad", 1'b0, 32'h10, 32'h0, BAD, 1'b0, 32'h0, 2'd1);
      req0("sbad", 1'b1, 32'h10, 32'h0, BAD, 1'b0, 32'h0, 2'd2);
      req0("lw10y", 1'b0, 32'h10, 32'h0, WD, 1'b0, 32'h8001_5678, 2'd0);
      idle0("exc");

      // Back-to-back, one response per cycle
      req0("bb_s0", 1'b1, 32'h20, 32'hA0A0_0001, WD, 1'b0, 32'h0, 2'd0);
      req0("bb_s1", 1'b1, 32'h24, 32'hA0A0_0002, WD, 1'b0, 32'h0, 2'd0);
      req0("bb_s2", 1'b1, 32'h28, 32'hA0A0_0003, WD, 1'b0, 32'h0, 2'd0);
      req0("bb_s3", 1'b1, 32'h2C, 32'hA0A0_0004, WD, 1'b0, 32'h0, 2'd0);
      req0("bb_l0", 1'b0, 32'h20, 32'h0, WD, 1'b0, 32'hA0A0_0001, 2'd0);
      req0("bb_l1", 1'b0, 32'h24, 32'h0, WD, 1'b0, 32'hA0A0_0002, 2'd0);
      req0("bb_l2", 1'b0, 32'h28, 32'h0, WD, 1'b0, 32'hA0A0_0003, 2'd0);
      req0("bb_l3", 1'b0, 32'h2C, 32'h0, WD, 1'b0, 32'hA0A0_0004, 2'd0);
      idle0("bb");

      // Wait states
      req3("w3_sw", 1'b1, 32'h10, 32'h5555_AAAA, WD, 1'b0, 32'h0, 2'd0);
      req3("w3_lw", 1'b0, 32'h10, 32'h0, WD, 1'b0, 32'h5555_AAAA, 2'd0);
      req3("w3_oor", 1'b0, 32'h100, 32'h0, WD, 1'b0, 32'h0, 2'd1);

      // Reset during WAIT of a store
      drive(1'b1, 32'h08, 32'hDEAD_BEEF, WD, 1'b0);
      v3 = 1'b1;
      @(posedge clk); #1;
      v3 = 1'b0;
      chk("rst_mid.in_wait", {31'd0, ready3}, 32'd0);
      @(posedge clk); #1;
      reset3 = 1'b1;
      @(posedge clk); #1;
      reset3 = 1'b0;
      chk("rst_mid.ready", {31'd0, ready3}, 32'd1);
      chk("rst_mid.valid", {31'd0, rv3}, 32'd0);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk("rst_mid.no_resp", {31'd0, rv3}, 32'd0);
      end
      req3("rst_lw08", 1'b0, 32'h08, 32'h0, WD, 1'b0, 32'h0, 2'd0);
      req3("rst_lw10", 1'b0, 32'h10, 32'h0, WD, 1'b0, 32'h0, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
